conn_to_tuple: RTL and testbench

CONN_TO_TUPLE -- requirements
Module: conn_to_tuple

---
 rtl/conn_to_tuple.sv | 125 ++++++++++++
 tb/tb_conn_to_tuple.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conn_to_tuple.sv
// Connection-ID to 5-tuple lookup: a register-file table written from a side port,
// read by request and streamed out as four 32-bit beats.
module conn_to_tuple #(
    parameter int HASH_LEN = 10,
    parameter int WIDTH    = 104
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [HASH_LEN-1:0] wr_id_i,
    input  logic [WIDTH-1:0]    wr_tuple_i,
    input  logic                id_valid_i,
    input  logic [31:0]         id_data_i,
    output logic                id_ready_o,
    output logic                tuple_valid_o,
    output logic [31:0]         tuple_data_o,
    output logic                tuple_last_o,
    output logic                tuple_miss_o,
    input  logic                tuple_ready_i
);

    localparam int DEPTH = 1 << HASH_LEN;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         id_q, id_d;
    logic [WIDTH-1:0]    buf_q, buf_d;
    logic                miss_q, miss_d;
    logic [1:0]          beat_q, beat_d;

    logic [WIDTH-1:0]    table_q [DEPTH];
    logic [HASH_LEN-1:0] rd_idx;
    logic [WIDTH-1:0]    rd_val;
    logic                out_of_range;

    // NOTE: the table has no reset branch; it keeps its contents across rst and maps to plain storage.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            table_q[wr_id_i] <= wr_tuple_i;
        end
    end

    // A write landing in the READ cycle is forwarded so the response sees the new tuple.
    assign rd_idx       = id_q[HASH_LEN-1:0];
    assign rd_val       = (wr_en_i && (wr_id_i == rd_idx)) ? wr_tuple_i : table_q[rd_idx];
    assign out_of_range = |id_q[31:HASH_LEN];

    // NOTE: every variable gets its default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        buf_d   = buf_q;
        miss_d  = miss_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (id_valid_i) begin
                    id_d    = id_data_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (out_of_range || (rd_val == '0)) begin
                    buf_d  = '0;
                    miss_d = 1'b1;
                end else begin
                    buf_d  = rd_val;
                    miss_d = 1'b0;
                end
                beat_d  = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                if (tuple_ready_i) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q  <= id_d;
        buf_q <= buf_d;
    end

    always_comb begin
        id_ready_o    = (state_q == IDLE);
        tuple_valid_o = (state_q == SEND);
        tuple_miss_o  = (state_q == SEND) && miss_q;
        tuple_last_o  = (state_q == SEND) && (beat_q == 2'd3);
        tuple_data_o  = '0;
        if (state_q == SEND) begin
            unique case (beat_q)
                2'd0: tuple_data_o = buf_q[31:0];
                2'd1: tuple_data_o = buf_q[63:32];
                2'd2: tuple_data_o = buf_q[95:64];
                2'd3: tuple_data_o = {24'b0, buf_q[103:96]};
                default: tuple_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_conn_to_tuple.sv
// Self-checking bench for conn_to_tuple: a queue-based response model checked every cycle,
// plus directed requests whose beats are compared against hand-computed literals.
module tb_conn_to_tuple;

    localparam int HL = 10;
    localparam int W  = 104;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [HL-1:0] wr_id;
    logic [W-1:0]  wr_tuple;
    logic          id_valid;
    logic [31:0]   id_data;
    logic          id_ready;
    logic          tuple_valid;
    logic [31:0]   tuple_data;
    logic          tuple_last;
    logic          tuple_miss;
    logic          tuple_ready;

    conn_to_tuple #(.HASH_LEN(HL), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_id_i      (wr_id),
        .wr_tuple_i   (wr_tuple),
        .id_valid_i   (id_valid),
        .id_data_i    (id_data),
        .id_ready_o   (id_ready),
        .tuple_valid_o(tuple_valid),
        .tuple_data_o (tuple_data),
        .tuple_last_o (tuple_last),
        .tuple_miss_o (tuple_miss),
        .tuple_ready_i(tuple_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] sip, input logic [31:0] dip,
                                        input logic [15:0] sport, input logic [15:0] dport,
                                        input logic [7:0] proto);
        return {proto, dport, sport, dip, sip};
    endfunction

    // Response model: a request becomes four expected beats one edge after it is accepted.
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        miss;
    } beat_t;

    beat_t        exp_q[$];
    logic         m_pending = 1'b0;
    logic [31:0]  m_pid;
    logic [W-1:0] m_table [1 << HL];
    logic [W-1:0] m_t;
    logic         m_miss;
    logic         m_rdy;
    bit           m_live = 1'b0;

    initial foreach (m_table[i]) m_table[i] = '0;

    always @(posedge clk) begin
        m_rdy = !m_pending && (exp_q.size() == 0);
        if (wr_en) m_table[wr_id] = wr_tuple;
        if (rst) begin
            m_pending = 1'b0;
            exp_q.delete();
            m_live = 1'b1;
        end else begin
            if (exp_q.size() > 0 && tuple_ready) void'(exp_q.pop_front());
            if (m_pending) begin
                m_t    = m_table[m_pid[HL-1:0]];
                m_miss = (m_pid >= (32'd1 << HL)) || (m_t == '0);
                if (m_miss) m_t = '0;
                exp_q.push_back('{m_t[31:0], 1'b0, m_miss});
                exp_q.push_back('{m_t[63:32], 1'b0, m_miss});
                exp_q.push_back('{{m_t[95:80], m_t[79:64]}, 1'b0, m_miss});
                exp_q.push_back('{{24'b0, m_t[103:96]}, 1'b1, m_miss});
                m_pending = 1'b0;
            end
            if (m_rdy && id_valid) begin
                m_pending = 1'b1;
                m_pid     = id_data;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (exp_q.size() > 0) begin
                check("cmp_valid", tuple_valid, 1);
                check("cmp_ready", id_ready, 0);
                check("cmp_data", tuple_data, exp_q[0].data);
                check("cmp_last", tuple_last, exp_q[0].last);
                check("cmp_miss", tuple_miss, exp_q[0].miss);
            end else begin
                check("cmp_valid", tuple_valid, 0);
                check("cmp_ready", id_ready, !m_pending);
                check("cmp_data", tuple_data, 0);
                check("cmp_last", tuple_last, 0);
                check("cmp_miss", tuple_miss, 0);
            end
        end
    end

    logic [31:0] got_data [4];
    logic        got_last [4];
    logic        got_miss [4];
    int          got_lat;

    task automatic wr(input logic [HL-1:0] id, input logic [W-1:0] t);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_id = id; wr_tuple = t;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic request(input logic [31:0] id, input int stall_beat, input int stall_n,
                           input bit byp, input logic [W-1:0] byp_t,
                           input bit send_wr, input logic [W-1:0] send_t);
        int n, b, left, guard;
        logic [31:0] held;
        got_lat = -1;
        foreach (got_data[i]) begin
            got_data[i] = 32'hDEADBEEF; got_last[i] = 1'bx; got_miss[i] = 1'bx;
        end
        @(posedge clk); #1;
        id_valid = 1'b1; id_data = id; tuple_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!id_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!id_ready) begin
            check("req_ready_timeout", 0, 1);
            id_valid = 1'b0;
            return;
        end
        n = cyc;
        @(posedge clk); #1;
        id_valid = 1'b0;
        if (byp) begin
            wr_en = 1'b1; wr_id = id[HL-1:0]; wr_tuple = byp_t;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        b = 0; left = stall_n; guard = 0; held = '0;
        while (b < 4 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (!tuple_valid) continue;
            if (b == 0 && got_lat < 0) got_lat = cyc - n;
            if (b == stall_beat && left > 0) begin
                if (left < stall_n) check("bp_hold", tuple_data, held);
                held = tuple_data;
                tuple_ready = 1'b0;
                left--;
            end else begin
                if (b == stall_beat && stall_n > 0) check("bp_hold", tuple_data, held);
                got_data[b] = tuple_data;
                got_last[b] = tuple_last;
                got_miss[b] = tuple_miss;
                tuple_ready = 1'b1;
                if (send_wr) begin
                    if (b == 1) begin
                        wr_en = 1'b1; wr_id = id[HL-1:0]; wr_tuple = send_t;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                b++;
            end
        end
        if (b < 4) check("beat_timeout", b, 4);
    endtask

    task automatic check_beats(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3, input logic miss);
        check({tag, "_b0"}, got_data[0], d0);
        check({tag, "_b1"}, got_data[1], d1);
        check({tag, "_b2"}, got_data[2], d2);
        check({tag, "_b3"}, got_data[3], d3);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_last"}, got_last[i], (i == 3) ? 1 : 0);
            check({tag, "_miss"}, got_miss[i], miss);
        end
    endtask

    int ready_cycles[$];
    int seen;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_id = '0; wr_tuple = '0;
        id_valid = 1'b0; id_data = '0; tuple_ready = 1'b1;

        // Bring every entry to its all-zero configuration value while reset is held.
        for (int i = 0; i < (1 << HL); i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_id = HL'(i); wr_tuple = '0;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_ready", id_ready, 1);
        check("rst_valid", tuple_valid, 0);
        check("rst_data", tuple_data, 0);
        check("rst_last", tuple_last, 0);
        check("rst_miss", tuple_miss, 0);

        // Hit on id 5.
        wr(5, mk(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h06));
        request(5, -1, 0, 0, '0, 0, '0);
        check_beats("hit5", 32'h0A000001, 32'h0A000002, 32'h00501234, 32'h00000006, 1'b0);
        check("hit5_latency", got_lat, 2);

        // Misses: unwritten entry and out-of-range IDs (0x405 aliases the populated entry 5).
        request(7, -1, 0, 0, '0, 0, '0);
        check_beats("miss7", 0, 0, 0, 0, 1'b1);
        request(32'h400, -1, 0, 0, '0, 0, '0);
        check_beats("miss400", 0, 0, 0, 0, 1'b1);
        request(32'h405, -1, 0, 0, '0, 0, '0);
        check_beats("miss405", 0, 0, 0, 0, 1'b1);

        // Backpressure on beat1 for three cycles.
        request(5, 1, 3, 0, '0, 0, '0);
        check_beats("bp5", 32'h0A000001, 32'h0A000002, 32'h00501234, 32'h00000006, 1'b0);

        // READ-cycle bypass, then a write during SEND that must not disturb the beats.
        wr(9, mk(32'hC0A80101, 32'hC0A80102, 16'h1111, 16'h2222, 8'h11));
        request(9, -1, 0, 1, mk(32'hAC100001, 32'hAC100002, 16'h0BB8, 16'h01BB, 8'h06),
                1, mk(32'h01020304, 32'h05060708, 16'h0A0B, 16'h0C0D, 8'h11));
        check_beats("byp9", 32'hAC100001, 32'hAC100002, 32'h01BB0BB8, 32'h00000006, 1'b0);
        request(9, -1, 0, 0, '0, 0, '0);
        check_beats("post9", 32'h01020304, 32'h05060708, 32'h0C0D0A0B, 32'h00000011, 1'b0);

        // Reset while beat2 is on the bus, with a request presented during reset.
        @(posedge clk); #1;
        id_valid = 1'b1; id_data = 5; tuple_ready = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0;
        seen = 0;
        for (int g = 0; g < 20 && seen < 3; g++) begin
            @(negedge clk);
            if (tuple_valid) seen++;
        end
        check("rstsend_reached_b2", seen, 3);
        check("rstsend_b2_data", tuple_data, 32'h00501234);
        rst = 1'b1; id_valid = 1'b1; id_data = 9;
        @(negedge clk);
        check("rstsend_valid", tuple_valid, 0);
        check("rstsend_ready", id_ready, 1);
        rst = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        check("rstsend_idle", id_ready, 1);
        request(5, -1, 0, 0, '0, 0, '0);
        check_beats("after_rst5", 32'h0A000001, 32'h0A000002, 32'h00501234, 32'h00000006, 1'b0);

        // Back-to-back requests with the sink always ready.
        @(posedge clk); #1;
        id_valid = 1'b1; id_data = 5; tuple_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id_ready) ready_cycles.push_back(cyc);
        end
        id_valid = 1'b0;
        check("tput_count", ready_cycles.size(), 5);
        for (int i = 1; i < ready_cycles.size(); i++)
            check("tput_gap", ready_cycles[i] - ready_cycles[i-1], 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_ready", id_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
